// File: rtl/arc_uarch_pkg.sv
// Shared ARC micro-architecture definitions: microword COND encodings,
// sequencer FSM states and the fetch microroutine entry address.
package arc_uarch_pkg;

  localparam logic [2:0] COND_NEXT   = 3'b000;
  localparam logic [2:0] COND_N      = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_V      = 3'b011;
  localparam logic [2:0] COND_C      = 3'b100;
  localparam logic [2:0] COND_IR13   = 3'b101;
  localparam logic [2:0] COND_JUMP   = 3'b110;
  localparam logic [2:0] COND_DECODE = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXEC     = 2'd1,
    ST_WAIT_MEM = 2'd2
  } seq_state_t;

  localparam logic [10:0] ADDR_FETCH = 11'd0;

  // Opcode-dispatch entry: a 1 in the MSB, op, op3, then a 4-word slot per opcode.
  function automatic logic [10:0] decode_addr(input logic [31:0] ir);
    return {1'b1, ir[31:30], ir[24:19], 2'b00};
  endfunction

endpackage

// File: rtl/cs_next_address.sv
// Combinational next-address mux: picks CSAddress+1, JumpAddress or the
// opcode-decode address from the microword COND field, PSR flags and IR.
module cs_next_address
  import arc_uarch_pkg::*;
#(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3
) (
  input  logic [DATAWIDTH_CONDITION-1:0]   i_cond,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] i_jump_addr,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] i_cs_addr,
  input  logic [3:0]                       i_psr,
  input  logic [31:0]                      i_ir,
  output logic [DATAWIDTH_JUMPADDRESS-1:0] o_next_addr
);

  logic [DATAWIDTH_JUMPADDRESS-1:0] w_incr_addr;
  logic [DATAWIDTH_JUMPADDRESS-1:0] w_decode_addr;
  logic                             w_flag_n;
  logic                             w_flag_z;
  logic                             w_flag_v;
  logic                             w_flag_c;
  logic                             w_taken;
  logic                             w_unused_ir;

  assign w_flag_n = i_psr[3];
  assign w_flag_z = i_psr[2];
  assign w_flag_v = i_psr[1];
  assign w_flag_c = i_psr[0];

  // Natural overflow of the address width gives the 2047 -> 0 wrap.
  assign w_incr_addr   = i_cs_addr + DATAWIDTH_JUMPADDRESS'(1);
  assign w_decode_addr = DATAWIDTH_JUMPADDRESS'(decode_addr(i_ir));
  assign w_unused_ir   = ^{i_ir[29:25], i_ir[18:14], i_ir[12:0]};

  always_comb begin
    w_taken = 1'b0;
    case (3'(i_cond))
      COND_N:    w_taken = w_flag_n;
      COND_Z:    w_taken = w_flag_z;
      COND_V:    w_taken = w_flag_v;
      COND_C:    w_taken = w_flag_c;
      COND_IR13: w_taken = i_ir[13];
      COND_JUMP: w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

  always_comb begin
    o_next_addr = w_incr_addr;
    if (3'(i_cond) == COND_DECODE) begin
      o_next_addr = w_decode_addr;
    end else if (w_taken) begin
      o_next_addr = i_jump_addr;
    end
  end

endmodule

// File: rtl/cs_address_sequencer.sv
// Microprogram sequencer: FETCH/EXEC microcycle with a WAIT_MEM stall for
// main-memory strobes; a stall that sees no ack recovers to the fetch routine.
module cs_address_sequencer
  import arc_uarch_pkg::*;
#(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_TIMEOUT     = 8,
  parameter int MEM_TIMEOUT_CYCLES    = 200
) (
  input  logic                             CS_ADDRESS_SEQUENCER_CLOCK_50,
  input  logic                             CS_ADDRESS_SEQUENCER_ResetInHigh_In,
  input  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
  input  logic                             CS_ADDRESS_SEQUENCER_RD_In,
  input  logic                             CS_ADDRESS_SEQUENCER_WR_In,
  input  logic [31:0]                      CS_ADDRESS_SEQUENCER_IR_InBus,
  input  logic [3:0]                       CS_ADDRESS_SEQUENCER_PSR_InBus,
  input  logic                             CS_ADDRESS_SEQUENCER_MemAck_In,
  output logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
  output logic                             CS_ADDRESS_SEQUENCER_MIRValid_Out,
  output logic                             CS_ADDRESS_SEQUENCER_Busy_Out,
  output logic                             CS_ADDRESS_SEQUENCER_MemTimeout_Out
);

  localparam logic [DATAWIDTH_TIMEOUT-1:0] TIMEOUT_LAST =
    DATAWIDTH_TIMEOUT'(MEM_TIMEOUT_CYCLES - 1);

  seq_state_t                       r_state;
  seq_state_t                       w_state_next;
  logic [DATAWIDTH_JUMPADDRESS-1:0] r_cs_addr;
  logic [DATAWIDTH_JUMPADDRESS-1:0] w_cs_addr_next;
  logic [DATAWIDTH_TIMEOUT-1:0]     r_wait_cnt;
  logic [DATAWIDTH_TIMEOUT-1:0]     w_wait_cnt_next;
  logic                             r_mem_timeout;
  logic                             w_mem_timeout_next;
  logic [DATAWIDTH_JUMPADDRESS-1:0] w_next_addr;
  logic                             w_mem_req;
  logic                             w_mem_ack;

  assign w_mem_req = CS_ADDRESS_SEQUENCER_RD_In | CS_ADDRESS_SEQUENCER_WR_In;
  assign w_mem_ack = CS_ADDRESS_SEQUENCER_MemAck_In;

  cs_next_address #(
    .DATAWIDTH_JUMPADDRESS (DATAWIDTH_JUMPADDRESS),
    .DATAWIDTH_CONDITION   (DATAWIDTH_CONDITION)
  ) u_next_address (
    .i_cond      (CS_ADDRESS_SEQUENCER_Condition_InBus),
    .i_jump_addr (CS_ADDRESS_SEQUENCER_JumpAddress_InBus),
    .i_cs_addr   (r_cs_addr),
    .i_psr       (CS_ADDRESS_SEQUENCER_PSR_InBus),
    .i_ir        (CS_ADDRESS_SEQUENCER_IR_InBus),
    .o_next_addr (w_next_addr)
  );

  always_comb begin
    w_state_next       = r_state;
    w_cs_addr_next     = r_cs_addr;
    w_wait_cnt_next    = r_wait_cnt;
    w_mem_timeout_next = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        // An ack already present in EXEC completes the access with no stall.
        if (w_mem_req && !w_mem_ack) begin
          w_state_next    = ST_WAIT_MEM;
          w_wait_cnt_next = '0;
        end else begin
          w_state_next   = ST_FETCH;
          w_cs_addr_next = w_next_addr;
        end
      end
      ST_WAIT_MEM: begin
        // Ack is tested first so a late ack on the final cycle still counts.
        if (w_mem_ack) begin
          w_state_next   = ST_FETCH;
          w_cs_addr_next = w_next_addr;
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          w_state_next       = ST_FETCH;
          w_cs_addr_next     = DATAWIDTH_JUMPADDRESS'(ADDR_FETCH);
          w_mem_timeout_next = 1'b1;
        end else begin
          w_wait_cnt_next = r_wait_cnt + DATAWIDTH_TIMEOUT'(1);
        end
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50) begin
    if (CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
      r_state       <= ST_FETCH;
      r_cs_addr     <= DATAWIDTH_JUMPADDRESS'(ADDR_FETCH);
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cs_addr     <= w_cs_addr_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_mem_timeout <= w_mem_timeout_next;
    end
  end

  assign CS_ADDRESS_SEQUENCER_CSAddress_OutBus = r_cs_addr;
  assign CS_ADDRESS_SEQUENCER_MIRValid_Out     = (r_state == ST_EXEC);
  assign CS_ADDRESS_SEQUENCER_Busy_Out         = (r_state == ST_WAIT_MEM);
  assign CS_ADDRESS_SEQUENCER_MemTimeout_Out   = r_mem_timeout;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Self-checking bench for cs_address_sequencer: directed scenarios plus a
// randomized run, scored against an arithmetic next-address model.
module tb_cs_address_sequencer;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cond;
  logic [10:0] jump;
  logic        rd;
  logic        wr;
  logic [31:0] ir;
  logic [3:0]  psr;
  logic        ack;
  logic [10:0] addr;
  logic        mir;
  logic        busy;
  logic        tmo;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_addr;
  int exp_next;

  int         o_exec_addr;
  logic       o_exec_mir;
  logic       o_exec_busy;
  logic       o_exec_tmo;
  int         o_wait;
  logic       o_hold_ok;
  int         o_end_addr;
  logic       o_end_mir;
  logic       o_end_busy;
  logic       o_pulse;
  logic [3:0] o_psr_used;

  always #5 clk = ~clk;

  cs_address_sequencer #(
    .DATAWIDTH_JUMPADDRESS (11),
    .DATAWIDTH_CONDITION   (3),
    .DATAWIDTH_TIMEOUT     (8),
    .MEM_TIMEOUT_CYCLES    (TMO)
  ) dut (
    .CS_ADDRESS_SEQUENCER_CLOCK_50         (clk),
    .CS_ADDRESS_SEQUENCER_ResetInHigh_In   (rst),
    .CS_ADDRESS_SEQUENCER_Condition_InBus  (cond),
    .CS_ADDRESS_SEQUENCER_JumpAddress_InBus(jump),
    .CS_ADDRESS_SEQUENCER_RD_In            (rd),
    .CS_ADDRESS_SEQUENCER_WR_In            (wr),
    .CS_ADDRESS_SEQUENCER_IR_InBus         (ir),
    .CS_ADDRESS_SEQUENCER_PSR_InBus        (psr),
    .CS_ADDRESS_SEQUENCER_MemAck_In        (ack),
    .CS_ADDRESS_SEQUENCER_CSAddress_OutBus (addr),
    .CS_ADDRESS_SEQUENCER_MIRValid_Out     (mir),
    .CS_ADDRESS_SEQUENCER_Busy_Out         (busy),
    .CS_ADDRESS_SEQUENCER_MemTimeout_Out   (tmo)
  );

  // Next address from the architectural rules: c selects n,z,v,c,IR13 for 1..5.
  function automatic int ref_next(int c, int j, int a, logic [3:0] p, logic [31:0] i);
    int sel_bit;
    sel_bit = 0;
    if (c == 0) return (a + 1) % 2048;
    if (c == 6) return j;
    if (c == 7) return 1024 + int'(i[31:30]) * 256 + int'(i[24:19]) * 4;
    if (c == 5) sel_bit = int'(i[13]);
    else        sel_bit = int'(p[4 - c]);
    return (sel_bit != 0) ? j : (a + 1) % 2048;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one microinstruction starting in FETCH. k=0: ack in EXEC; k>0: ack on
  // the k-th WAIT_MEM cycle; k<0: never ack. Without a strobe, k>0 drives a
  // stray ack in EXEC that must be ignored.
  task automatic do_uinstr(input logic [2:0] c, input logic [10:0] j, input logic [3:0] p,
                           input logic [31:0] i, input logic r, input logic w, input int k);
    logic mem;
    int   nwait;
    mem  = r | w;
    cond = c; jump = j; psr = p; ir = i; rd = r; wr = w;
    ack  = mem ? (k == 0) : (k > 0);
    step();
    o_exec_addr = int'(addr);
    o_exec_mir  = mir;
    o_exec_busy = busy;
    o_exec_tmo  = tmo;
    o_wait      = 0;
    o_hold_ok   = 1'b1;
    if (mem && k != 0) begin
      ack = 1'b0;
      step();
      nwait = (k > 0) ? k : TMO;
      for (int n = 0; n < nwait; n++) begin
        if (busy !== 1'b1 || int'(addr) != o_exec_addr || tmo !== 1'b0 || mir !== 1'b0)
          o_hold_ok = 1'b0;
        else
          o_wait++;
        psr = 4'($urandom);
        if (k > 0 && n == k - 1) ack = 1'b1;
        step();
      end
    end else begin
      step();
    end
    o_psr_used = psr;
    ack = 1'b0; rd = 1'b0; wr = 1'b0;
    o_end_addr = int'(addr);
    o_end_mir  = mir;
    o_end_busy = busy;
    o_pulse    = tmo;
  endtask

  task automatic test_reset();
    rst = 1'b1; cond = '0; jump = '0; rd = 1'b0; wr = 1'b0; ir = '0; psr = '0; ack = 1'b0;
    step();
    step();
    n_tests++; if (addr !== 11'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    n_tests++; if (mir !== 1'b0) begin n_fail++; $display("FAIL reset_mir: got %b expected 0", mir); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b expected 0", tmo); end
    rst = 1'b0;
    exp_addr = 0;
  endtask

  task automatic test_sequential();
    for (int n = 0; n < 3; n++) begin
      do_uinstr(3'b000, 11'd0, 4'd0, 32'd0, 1'b0, 1'b0, -1);
      n_tests++; if (o_exec_addr != n) begin n_fail++; $display("FAIL seq_exec_addr%0d: got %0d expected %0d", n, o_exec_addr, n); end
      n_tests++; if (o_exec_mir !== 1'b1) begin n_fail++; $display("FAIL seq_mir_exec%0d: got %b expected 1", n, o_exec_mir); end
      n_tests++; if (o_end_mir !== 1'b0) begin n_fail++; $display("FAIL seq_mir_fetch%0d: got %b expected 0", n, o_end_mir); end
    end
    exp_addr = 3;
    n_tests++; if (o_end_addr != exp_addr) begin n_fail++; $display("FAIL seq_end_addr: got %0d expected %0d", o_end_addr, exp_addr); end
  endtask

  task automatic test_decode();
    do_uinstr(3'b110, 11'd1, 4'd0, 32'd0, 1'b0, 1'b0, -1);
    n_tests++; if (o_end_addr != 1) begin n_fail++; $display("FAIL dec_jump_to_1: got %0d expected 1", o_end_addr); end
    do_uinstr(3'b111, 11'd5, 4'd0, 32'h8080_0000, 1'b0, 1'b0, -1);
    n_tests++; if (o_end_addr != 1600) begin n_fail++; $display("FAIL dec_addcc: got %0d expected 1600", o_end_addr); end
    do_uinstr(3'b111, 11'd5, 4'd0, 32'h0080_0000, 1'b0, 1'b0, -1);
    n_tests++; if (o_end_addr != 1088) begin n_fail++; $display("FAIL dec_op00: got %0d expected 1088", o_end_addr); end
    exp_addr = 1088;
  endtask

  task automatic test_branch();
    do_uinstr(3'b110, 11'd1094, 4'd0, 32'd0, 1'b0, 1'b0, -1);
    do_uinstr(3'b010, 11'd1604, 4'b0100, 32'd0, 1'b0, 1'b0, -1);
    n_tests++; if (o_exec_addr != 1094) begin n_fail++; $display("FAIL br_exec_addr: got %0d expected 1094", o_exec_addr); end
    n_tests++; if (o_end_addr != 1604) begin n_fail++; $display("FAIL br_z_taken: got %0d expected 1604", o_end_addr); end
    do_uinstr(3'b110, 11'd1094, 4'd0, 32'd0, 1'b0, 1'b0, -1);
    do_uinstr(3'b010, 11'd1604, 4'b1011, 32'd0, 1'b0, 1'b0, -1);
    n_tests++; if (o_end_addr != 1095) begin n_fail++; $display("FAIL br_z_not_taken: got %0d expected 1095", o_end_addr); end
    exp_addr = 1095;
  endtask

  task automatic test_mem();
    do_uinstr(3'b000, 11'd0, 4'd0, 32'd0, 1'b1, 1'b0, 3);
    n_tests++; if (o_exec_busy !== 1'b0) begin n_fail++; $display("FAIL mem_exec_busy: got %b expected 0", o_exec_busy); end
    n_tests++; if (o_wait != 3 || o_hold_ok !== 1'b1) begin n_fail++; $display("FAIL mem_wait3: got %0d cycles hold=%b expected 3 hold=1", o_wait, o_hold_ok); end
    n_tests++; if (o_end_addr != 1096 || o_end_busy !== 1'b0) begin n_fail++; $display("FAIL mem_wait3_end: got %0d busy=%b expected 1096 busy=0", o_end_addr, o_end_busy); end
    do_uinstr(3'b000, 11'd0, 4'd0, 32'd0, 1'b1, 1'b0, 0);
    n_tests++; if (o_end_busy !== 1'b0 || o_end_addr != 1097) begin n_fail++; $display("FAIL mem_ack_exec: got %0d busy=%b expected 1097 busy=0", o_end_addr, o_end_busy); end
    exp_addr = 1097;
    do_uinstr(3'b001, 11'd300, 4'd0, 32'd0, 1'b0, 1'b1, 2);
    exp_next = ref_next(1, 300, exp_addr, o_psr_used, 32'd0);
    n_tests++; if (o_end_addr != exp_next) begin n_fail++; $display("FAIL mem_psr_at_ack: got %0d expected %0d", o_end_addr, exp_next); end
    exp_addr = exp_next;
  endtask

  task automatic test_timeout();
    do_uinstr(3'b110, 11'd500, 4'd0, 32'd0, 1'b1, 1'b0, -1);
    n_tests++; if (o_wait != TMO || o_hold_ok !== 1'b1) begin n_fail++; $display("FAIL tmo_wait: got %0d hold=%b expected %0d hold=1", o_wait, o_hold_ok, TMO); end
    n_tests++; if (o_pulse !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got %b expected 1", o_pulse); end
    n_tests++; if (o_end_addr != 0 || o_end_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_addr: got %0d busy=%b expected 0 busy=0", o_end_addr, o_end_busy); end
    do_uinstr(3'b000, 11'd0, 4'd0, 32'd0, 1'b0, 1'b0, -1);
    n_tests++; if (o_exec_tmo !== 1'b0 || o_exec_addr != 0) begin n_fail++; $display("FAIL tmo_one_cycle: got tmo=%b addr=%0d expected tmo=0 addr=0", o_exec_tmo, o_exec_addr); end
    do_uinstr(3'b110, 11'd77, 4'd0, 32'd0, 1'b1, 1'b0, TMO);
    n_tests++; if (o_pulse !== 1'b0 || o_end_addr != 77 || o_wait != TMO) begin n_fail++; $display("FAIL tmo_ack_wins: got addr=%0d pulse=%b wait=%0d expected 77 0 %0d", o_end_addr, o_pulse, o_wait, TMO); end
    exp_addr = 77;
  endtask

  task automatic test_reset_in_wait();
    cond = 3'b000; rd = 1'b1; ack = 1'b0;
    step();
    step();
    step();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstw_in_wait: got busy=%b expected 1", busy); end
    rst = 1'b1;
    step();
    n_tests++; if (addr !== 11'd0 || busy !== 1'b0 || mir !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("FAIL rstw_state: got addr=%0d busy=%b mir=%b tmo=%b expected 0 0 0 0", addr, busy, mir, tmo); end
    rst = 1'b0; rd = 1'b0;
    exp_addr = 0;
    do_uinstr(3'b000, 11'd0, 4'd0, 32'd0, 1'b0, 1'b0, -1);
    n_tests++; if (o_exec_addr != 0 || o_exec_mir !== 1'b1) begin n_fail++; $display("FAIL rstw_resume: got addr=%0d mir=%b expected 0 1", o_exec_addr, o_exec_mir); end
    exp_addr = 1;
  endtask

  task automatic test_wrap();
    do_uinstr(3'b110, 11'd2047, 4'd0, 32'd0, 1'b0, 1'b0, -1);
    do_uinstr(3'b000, 11'd0, 4'd0, 32'd0, 1'b0, 1'b0, -1);
    n_tests++; if (o_exec_addr != 2047 || o_end_addr != 0) begin n_fail++; $display("FAIL wrap: got %0d->%0d expected 2047->0", o_exec_addr, o_end_addr); end
    exp_addr = 0;
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [10:0] j;
    logic [3:0]  p;
    logic [31:0] i;
    logic        r;
    logic        w;
    int          k;
    for (int n = 0; n < 60; n++) begin
      c = 3'($urandom_range(0, 7));
      j = 11'($urandom_range(0, 2047));
      p = 4'($urandom);
      i = $urandom;
      r = 1'b0; w = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) r = 1'b1; else w = 1'b1;
      end
      k = $urandom_range(0, 5);
      do_uinstr(c, j, p, i, r, w, k);
      exp_next = ref_next(int'(c), int'(j), exp_addr, o_psr_used, i);
      n_tests++; if (o_exec_addr != exp_addr) begin n_fail++; $display("FAIL rnd_exec%0d: got %0d expected %0d", n, o_exec_addr, exp_addr); end
      n_tests++; if (o_end_addr != exp_next) begin n_fail++; $display("FAIL rnd_next%0d: got %0d expected %0d (cond=%0d)", n, o_end_addr, exp_next, c); end
      if ((r | w) && k > 0) begin
        n_tests++; if (o_wait != k || o_hold_ok !== 1'b1) begin n_fail++; $display("FAIL rnd_wait%0d: got %0d hold=%b expected %0d hold=1", n, o_wait, o_hold_ok, k); end
      end
      exp_addr = exp_next;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_decode();
    test_branch();
    test_mem();
    test_timeout();
    test_reset_in_wait();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cs_address_sequencer.md
# cs_address_sequencer

Microprogram sequencer for the ARC microcoded datapath. It drives the 11-bit control-store address into the microcode store and evaluates the registered microword's condition field, jump address, memory strobes, PSR flags and instruction-register fields to pick the next address: next, jump or decode. It also stalls the microcycle while a main-memory access is outstanding, with a timeout that recovers to the fetch microroutine.

## Interface
Parameters:
- DATAWIDTH_JUMPADDRESS, 11, control-store address width
- DATAWIDTH_CONDITION, 3, microword COND field width
- DATAWIDTH_TIMEOUT, 8, memory-wait counter width
- MEM_TIMEOUT_CYCLES, 200, wait cycles before abort (must be < 2^DATAWIDTH_TIMEOUT)

Ports. One clock; reset is synchronous and active-high.
- CS_ADDRESS_SEQUENCER_CLOCK_50  in  1  system clock
- CS_ADDRESS_SEQUENCER_ResetInHigh_In  in  1  synchronous active-high reset
- CS_ADDRESS_SEQUENCER_Condition_InBus  in  3  COND field of the current microword
- CS_ADDRESS_SEQUENCER_JumpAddress_InBus  in  11  JUMP ADDR field of the current microword
- CS_ADDRESS_SEQUENCER_RD_In  in  1  microword memory-read strobe
- CS_ADDRESS_SEQUENCER_WR_In  in  1  microword memory-write strobe
- CS_ADDRESS_SEQUENCER_IR_InBus  in  32  instruction register contents
- CS_ADDRESS_SEQUENCER_PSR_InBus  in  4  PSR flags {n,z,v,c}
- CS_ADDRESS_SEQUENCER_MemAck_In  in  1  main-memory completion, 1-cycle pulse
- CS_ADDRESS_SEQUENCER_CSAddress_OutBus  out  11  registered control-store address
- CS_ADDRESS_SEQUENCER_MIRValid_Out  out  1  high in EXEC: microword fields valid, datapath may commit
- CS_ADDRESS_SEQUENCER_Busy_Out  out  1  high in WAIT_MEM
- CS_ADDRESS_SEQUENCER_MemTimeout_Out  out  1  1-cycle pulse on memory timeout

## Operation
FSM states: FETCH, EXEC, WAIT_MEM.
- FETCH: the address is stable. The microcode store registers the microword on this edge. Always go to EXEC.
- EXEC: the microword is valid and MIRValid_Out=1.
  - If RD or WR is 1 and MemAck is 0: go to WAIT_MEM and clear the timeout counter.
  - Otherwise: load CSAddress with next_addr and go to FETCH.
- WAIT_MEM: hold the address.
  - On MemAck: load next_addr and go to FETCH.
  - If the counter reaches MEM_TIMEOUT_CYCLES-1 without an ack: load address 0, pulse MemTimeout_Out, go to FETCH.
  - Otherwise: increment the counter.
  - MemAck and timeout on the same cycle: the ack wins.
- next_addr is selected by COND:
  - 000: CSAddress+1
  - 001: n
  - 010: z
  - 011: v
  - 100: c
  - 101: IR[13]
  - 110: always JUMP
  - 111: DECODE
  - For 001–101, the address is JumpAddress if the tested bit is 1, else CSAddress+1.
- DECODE address = {1'b1, IR[31:30], IR[24:19], 2'b00}. For example, addcc (op=10, op3=010000) decodes to 1600, and op=00 with IR[24:19]=010000 decodes to 1088.
- CSAddress+1 wraps from 2047 to 0, modulo 2^11.
- PSR and IR are sampled combinationally in the EXEC or ack cycle. The sequencer holds no copy of them.
- MemAck outside EXEC/WAIT_MEM, or in EXEC with RD=WR=0, is ignored.

## Timing
- Reset values: CSAddress=0, state=FETCH, MIRValid=0, Busy=0, MemTimeout=0, counter=0.
- Reset overrides every state, including WAIT_MEM mid-access. The next state after reset is FETCH at address 0.
- A microinstruction without a memory access takes exactly 2 cycles (FETCH then EXEC).
- A memory access takes 2 + k cycles, where k is the number of WAIT_MEM cycles before the ack. If MemAck arrives in EXEC, k=0.
- A timeout occurs after exactly MEM_TIMEOUT_CYCLES cycles in WAIT_MEM.
- CSAddress changes only on the clock edge leaving EXEC or WAIT_MEM.
- Busy_Out is asserted exactly in WAIT_MEM.

## Structure
- Shared package (arc_uarch_pkg):
  - COND encodings: COND_NEXT, COND_N, COND_Z, COND_V, COND_C, COND_IR13, COND_JUMP, COND_DECODE.
  - FSM state enum.
  - Constant ADDR_FETCH=11'd0.
- Sub-module cs_next_address: purely combinational next-address mux. Inputs are COND, JumpAddress, CSAddress, PSR and IR; output is next_addr. It is unit-testable standalone.
- The top level holds the FSM, the address register and the timeout counter.

## Test plan
- Reset then run with COND=000 and no memory access → addresses 0,1,2 on successive EXEC cycles; MIRValid toggles 0,1,0,1.
- At address 1 with COND=111 and IR=0x80800000 (op=10, op3=010000) → next CSAddress=1600.
- At address 1094 with COND=010 and JumpAddress=1604: PSR z=1 → 1604; z=0 → 1095.
- RD=1 with MemAck 3 cycles into WAIT_MEM → Busy high for 3 cycles, address held, then next_addr. RD=1 with MemAck in EXEC → no WAIT_MEM.
- RD=1, no ack, MEM_TIMEOUT_CYCLES=200 → MemTimeout pulses after 200 WAIT_MEM cycles and CSAddress=0. Ack on the timeout cycle → normal advance, no pulse.
- Reset asserted while in WAIT_MEM → next cycle: FETCH, CSAddress=0, Busy=0. At CSAddress=2047 with COND=000 → wraps to 0.
